// File: rtl/fir_bridge_pkg.sv
// Shared widths and state encodings for the FIR byte bridge.
package fir_bridge_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned IDX_W          = 2;
    localparam int unsigned ASM_W          = WORD_W - BYTE_W;

    typedef enum logic {
        RX_COLLECT = 1'b0,
        RX_WAIT    = 1'b1
    } rx_state_e;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_e;

endpackage : fir_bridge_pkg

// File: rtl/fir_bridge_fifo.sv
// Small circular word FIFO with occupancy counter; push while full is
// accepted only when a pop happens on the same edge.
module fir_bridge_fifo #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic              pop_i,
    output logic [WORD_W-1:0] head_c,
    output logic              full_c,
    output logic              empty_c
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_push;
    logic              do_pop;

    assign full_c  = (count_q == CNT_W'(DEPTH));
    assign empty_c = (count_q == '0);
    assign head_c  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_c;
    assign do_push = push_i && (!full_c || do_pop);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage write; contents are don't-care while empty so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule : fir_bridge_fifo

// File: rtl/fir_byte_bridge.sv
// Byte-stream bridge around a 32-bit FIR core: RX packs host bytes into
// sample words, TX queues result words and serialises them LSB byte first.
module fir_byte_bridge
    import fir_bridge_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] x_dat,
    input  logic        x_lz,
    input  logic [31:0] y_dat,
    input  logic        y_lz,
    output logic        overrun
);

    rx_state_e          rx_state_q;
    logic [IDX_W-1:0]   rx_idx_q;
    logic [ASM_W-1:0]   asm_q;
    logic [WORD_W-1:0]  x_dat_q;

    tx_state_e          tx_state_q;
    logic [IDX_W-1:0]   tx_idx_q;
    logic [WORD_W-1:0]  shift_q;
    logic               overrun_q;

    logic [WORD_W-1:0]  fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;

    // Handshake outputs are forced low while reset is asserted.
    assign in_ready  = (rx_state_q == RX_COLLECT) && !rst;
    assign out_valid = (tx_state_q == TX_SEND) && !rst;
    assign out_data  = shift_q[BYTE_W-1:0];
    assign x_dat     = x_dat_q;
    assign overrun   = overrun_q;
    assign fifo_pop  = (tx_state_q == TX_IDLE) && !fifo_empty;

    // RX: assemble four bytes little-endian, then hold until the core consumes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= RX_COLLECT;
            rx_idx_q   <= '0;
            asm_q      <= '0;
            x_dat_q    <= '0;
        end else begin
            case (rx_state_q)
                RX_COLLECT: begin
                    if (in_valid) begin
                        if (rx_idx_q == IDX_W'(BYTES_PER_WORD - 1)) begin
                            x_dat_q    <= {in_data, asm_q};
                            rx_idx_q   <= '0;
                            rx_state_q <= RX_WAIT;
                        end else begin
                            case (rx_idx_q)
                                2'd0:    asm_q[7:0]   <= in_data;
                                2'd1:    asm_q[15:8]  <= in_data;
                                default: asm_q[23:16] <= in_data;
                            endcase
                            rx_idx_q <= rx_idx_q + IDX_W'(1);
                        end
                    end
                end
                RX_WAIT: begin
                    if (x_lz) begin
                        rx_state_q <= RX_COLLECT;
                    end
                end
                default: rx_state_q <= RX_COLLECT;
            endcase
        end
    end

    // Result words queue here between the core and the TX serialiser.
    fir_bridge_fifo #(
        .WORD_W (WORD_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (y_lz),
        .data_i  (y_dat),
        .pop_i   (fifo_pop),
        .head_c  (fifo_head),
        .full_c  (fifo_full),
        .empty_c (fifo_empty)
    );

    // Sticky flag for a result word that found the FIFO full with no pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else if (y_lz && fifo_full && !fifo_pop) begin
            overrun_q <= 1'b1;
        end
    end

    // TX: load head word on pop, then shift out one byte per accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_idx_q   <= '0;
            shift_q    <= '0;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (!fifo_empty) begin
                        shift_q    <= fifo_head;
                        tx_idx_q   <= '0;
                        tx_state_q <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (out_ready) begin
                        if (tx_idx_q == IDX_W'(BYTES_PER_WORD - 1)) begin
                            tx_state_q <= TX_IDLE;
                        end else begin
                            shift_q  <= shift_q >> BYTE_W;
                            tx_idx_q <= tx_idx_q + IDX_W'(1);
                        end
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

endmodule : fir_byte_bridge

// File: tb/tb_fir_byte_bridge.sv
// Directed scoreboard bench for fir_byte_bridge.
module tb_fir_byte_bridge;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] x_dat;
    logic        x_lz;
    logic [31:0] y_dat;
    logic        y_lz;
    logic        overrun;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q [$];

    fir_byte_bridge #(.FIFO_DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_dat     (x_dat),
        .x_lz      (x_lz),
        .y_dat     (y_dat),
        .y_lz      (y_lz),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: every presented byte must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL stale_byte: got 0x%0h with nothing expected", out_data);
            end else begin
                check("out_byte", 32'(out_data), 32'(exp_q[0]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", n_errors);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: byte 0x%0h never accepted", b);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic y_push(input logic [31:0] w, input bit accepted);
        if (accepted) begin
            for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
        end
        y_dat = w;
        y_lz  = 1'b1;
        tick();
        y_lz  = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        x_lz = 1'b0; y_dat = '0; y_lz = 1'b0;
        repeat (3) tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_x_dat", x_dat, 32'h0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Byte assembly and WAIT/x_lz handshake
        send_word(32'h44332211);
        check("x_dat_word1", x_dat, 32'h44332211);
        check("wait_in_ready", 32'(in_ready), 32'd0);
        repeat (3) tick();
        check("wait_hold_in_ready", 32'(in_ready), 32'd0);
        check("x_dat_hold", x_dat, 32'h44332211);
        x_lz = 1'b1; tick(); x_lz = 1'b0;
        check("x_lz_release", 32'(in_ready), 32'd1);
        x_lz = 1'b1; tick(); x_lz = 1'b0;
        check("x_lz_ignored", 32'(in_ready), 32'd1);
        send_word(32'hDDCCBBAA);
        check("x_dat_word2", x_dat, 32'hDDCCBBAA);
        x_lz = 1'b1; tick(); x_lz = 1'b0;

        // Latency and byte order with host always ready
        out_ready = 1'b1;
        y_push(32'hDEADBEEF, 1'b1);
        check("lat_n1_valid", 32'(out_valid), 32'd0);
        tick();
        check("lat_n2_valid", 32'(out_valid), 32'd1);
        check("lat_b0", 32'(out_data), 32'hEF);
        tick(); check("lat_b1", 32'(out_data), 32'hBE);
        tick(); check("lat_b2", 32'(out_data), 32'hAD);
        tick(); check("lat_b3", 32'(out_data), 32'hDE);
        tick(); check("lat_done_valid", 32'(out_valid), 32'd0);
        drain("drain_deadbeef");

        // Back-pressure mid-word
        y_push(32'h0A0B0C0D, 1'b1);
        repeat (3) tick();
        out_ready = 1'b0;
        repeat (5) tick();
        check("stall_hold", 32'(out_data), 32'h0B);
        check("stall_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        drain("drain_stall");

        // Overrun: shifter plus two FIFO entries, fourth word dropped
        out_ready = 1'b0;
        y_push(32'h00000001, 1'b1);
        y_push(32'h00000002, 1'b1);
        y_push(32'h00000003, 1'b1);
        check("no_overrun_yet", 32'(overrun), 32'd0);
        y_push(32'h00000004, 1'b0);
        check("overrun_set", 32'(overrun), 32'd1);
        repeat (5) tick();
        out_ready = 1'b1;
        drain("drain_overrun");
        check("overrun_sticky", 32'(overrun), 32'd1);

        // Simultaneous pop and push with the FIFO full
        do_reset();
        check("overrun_cleared", 32'(overrun), 32'd0);
        out_ready = 1'b0;
        y_push(32'hA0A1A2A3, 1'b1);
        y_push(32'hB0B1B2B3, 1'b1);
        y_push(32'hC0C1C2C3, 1'b1);
        repeat (2) tick();
        out_ready = 1'b1;
        repeat (4) tick();
        check("pop_cycle_idle", 32'(out_valid), 32'd0);
        y_push(32'hD0D1D2D3, 1'b1);
        drain("drain_full_pushpop");
        check("pushpop_no_overrun", 32'(overrun), 32'd0);

        // Mid-operation reset discards partial and queued words
        out_ready = 1'b0;
        y_push(32'h55667788, 1'b1);
        tick();
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        check("pre_rst_send", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_comb_in_ready", 32'(in_ready), 32'd0);
        check("rst_comb_out_valid", 32'(out_valid), 32'd0);
        exp_q.delete();
        tick();
        check("rst_in_ready2", 32'(in_ready), 32'd0);
        check("rst_out_valid2", 32'(out_valid), 32'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (10) tick();
        check("no_stale_valid", 32'(out_valid), 32'd0);
        send_word(32'h40302010);
        check("x_dat_after_rst", x_dat, 32'h40302010);
        repeat (5) tick();
        check("no_stale_valid2", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fir_byte_bridge
